// File: rtl/ps2_pkg.sv
// Shared PS/2 device-emulator definitions: FSM states, protocol bytes, frame builder.
package ps2_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned RX_BITS    = 10;

   typedef enum logic [2:0] {
      IDLE,
      TX_BIT,
      TX_GAP,
      INHIBIT,
      RX_WAIT,
      RX_BIT,
      RX_ACK,
      RESP
   } ps2_state_t;

   localparam logic [BYTE_W-1:0] CMD_ED = 8'hED;
   localparam logic [BYTE_W-1:0] CMD_FF = 8'hFF;
   localparam logic [BYTE_W-1:0] RSP_FA = 8'hFA;
   localparam logic [BYTE_W-1:0] RSP_FE = 8'hFE;
   localparam logic [BYTE_W-1:0] RSP_AA = 8'hAA;

   // Device-to-host frame, bit 0 goes out first: start, data LSB-first, odd parity, stop.
   function automatic logic [FRAME_BITS-1:0] tx_frame(input logic [BYTE_W-1:0] data);
      return {1'b1, ~(^data), data, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Scan-code queue with a show-ahead head; a write alongside a pop is accepted even when full.
module ps2_byte_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [BYTE_W-1:0] wdata,
   input  logic              rd,
   output logic [BYTE_W-1:0] head,
   output logic              empty,
   output logic              full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [CW-1:0]     count;
   logic              do_wr;
   logic              do_rd;

   assign do_rd = rd && !empty;
   assign do_wr = wr && (!full || do_rd);
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign head  = mem[rptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/ps2_device_emulator.sv
// PS/2 keyboard-side emulator: sends queued scan codes, receives host commands
// (ED lock LEDs, FF reset) and answers with FA/FE/AA ahead of the queue.
module ps2_device_emulator
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HALF    = 1250,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned GAP_CYC     = 2500,
   parameter int unsigned INHIBIT_CYC = 5000
) (
   input  logic              CLOCK_50,
   input  logic              Resetn,
   input  logic              key_action,
   input  logic [BYTE_W-1:0] scan_code,
   output logic              ps2_clk_o,
   output logic              ps2_dat_o,
   input  logic              ps2_clk_i,
   input  logic              ps2_dat_i,
   output logic [2:0]        ps2_lock_control,
   output logic              fifo_full,
   output logic              overflow,
   output logic              rx_error
);

   localparam int unsigned TW = $clog2(2 * CLK_HALF + GAP_CYC + INHIBIT_CYC + 1);
   localparam logic [TW-1:0] HALF_END = TW'(CLK_HALF - 1);
   localparam logic [TW-1:0] BIT_END  = TW'(2 * CLK_HALF - 1);
   localparam logic [TW-1:0] SAMPLE   = TW'(CLK_HALF + CLK_HALF / 2);
   localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYC - 1);
   localparam logic [TW-1:0] INH_END  = TW'(INHIBIT_CYC - 1);

   ps2_state_t            state;
   logic [TW-1:0]         tcnt;
   logic [3:0]            bit_idx;
   logic [FRAME_BITS-1:0] frame;
   logic                  tx_resp;
   logic                  pop;
   logic [1:0]            resp_cnt;
   logic [BYTE_W-1:0]     resp0;
   logic [BYTE_W-1:0]     resp1;
   logic                  lock_armed;
   logic [RX_BITS-1:0]    rx_sr;
   logic [BYTE_W-1:0]     head;
   logic                  fifo_empty;

   ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLOCK_50),
      .rst_n (Resetn),
      .wr    (key_action),
      .wdata (scan_code),
      .rd    (pop),
      .head  (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state            <= IDLE;
         tcnt             <= '0;
         bit_idx          <= '0;
         frame            <= '1;
         tx_resp          <= 1'b0;
         pop              <= 1'b0;
         resp_cnt         <= '0;
         resp0            <= '0;
         resp1            <= '0;
         lock_armed       <= 1'b0;
         rx_sr            <= '0;
         ps2_clk_o        <= 1'b1;
         ps2_dat_o        <= 1'b1;
         ps2_lock_control <= '0;
         overflow         <= 1'b0;
         rx_error         <= 1'b0;
      end else begin
         pop      <= 1'b0;
         rx_error <= 1'b0;
         if (key_action && fifo_full && !pop) overflow <= 1'b1;

         case (state)
            IDLE: begin
               ps2_clk_o <= 1'b1;
               ps2_dat_o <= 1'b1;
               if (!ps2_clk_i) begin
                  // Host holding the clock long enough means it wants to talk.
                  if (tcnt == INH_END) begin
                     state <= INHIBIT;
                     tcnt  <= '0;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end else begin
                  tcnt <= '0;
                  if (resp_cnt != 2'd0 || !fifo_empty) begin
                     frame     <= tx_frame((resp_cnt != 2'd0) ? resp0 : head);
                     tx_resp   <= (resp_cnt != 2'd0);
                     state     <= TX_BIT;
                     bit_idx   <= '0;
                     ps2_dat_o <= 1'b0;
                  end
               end
            end

            TX_BIT: begin
               if (ps2_clk_o && !ps2_clk_i) begin
                  // Host pulled the clock while we released it: abort, keep the byte.
                  state     <= INHIBIT;
                  tcnt      <= '0;
                  ps2_clk_o <= 1'b1;
                  ps2_dat_o <= 1'b1;
               end else if (tcnt == HALF_END) begin
                  ps2_clk_o <= 1'b0;
                  tcnt      <= tcnt + 1'b1;
               end else if (tcnt == BIT_END) begin
                  tcnt      <= '0;
                  ps2_clk_o <= 1'b1;
                  if (bit_idx == 4'(FRAME_BITS - 1)) begin
                     state     <= TX_GAP;
                     ps2_dat_o <= 1'b1;
                     if (tx_resp) begin
                        resp0    <= resp1;
                        resp_cnt <= resp_cnt - 1'b1;
                     end else begin
                        pop <= 1'b1;
                     end
                  end else begin
                     bit_idx   <= bit_idx + 1'b1;
                     ps2_dat_o <= frame[1];
                     frame     <= {1'b1, frame[FRAME_BITS-1:1]};
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            TX_GAP: begin
               ps2_clk_o <= 1'b1;
               ps2_dat_o <= 1'b1;
               if (tcnt == GAP_END) begin
                  state <= IDLE;
                  tcnt  <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            INHIBIT: begin
               ps2_clk_o <= 1'b1;
               ps2_dat_o <= 1'b1;
               tcnt      <= '0;
               if (ps2_clk_i) state <= RX_WAIT;
            end

            RX_WAIT: begin
               tcnt    <= '0;
               bit_idx <= '0;
               state   <= ps2_dat_i ? IDLE : RX_BIT;
            end

            RX_BIT: begin
               if (tcnt == SAMPLE) rx_sr <= {ps2_dat_i, rx_sr[RX_BITS-1:1]};
               if (tcnt == HALF_END) begin
                  ps2_clk_o <= 1'b0;
                  tcnt      <= tcnt + 1'b1;
               end else if (tcnt == BIT_END) begin
                  tcnt      <= '0;
                  ps2_clk_o <= 1'b1;
                  if (bit_idx == 4'(RX_BITS - 1)) begin
                     state     <= RX_ACK;
                     ps2_dat_o <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            RX_ACK: begin
               if (tcnt == HALF_END) begin
                  ps2_clk_o <= 1'b0;
                  tcnt      <= tcnt + 1'b1;
               end else if (tcnt == BIT_END) begin
                  tcnt      <= '0;
                  ps2_clk_o <= 1'b1;
                  ps2_dat_o <= 1'b1;
                  state     <= RESP;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            RESP: begin
               state    <= IDLE;
               resp_cnt <= 2'd1;
               resp0    <= RSP_FA;
               // rx_sr = {stop, parity, data}; data plus parity must hold an odd count of ones.
               if (!(^rx_sr[BYTE_W:0]) || !rx_sr[RX_BITS-1]) begin
                  rx_error <= 1'b1;
                  resp0    <= RSP_FE;
               end else if (lock_armed) begin
                  ps2_lock_control <= rx_sr[2:0];
                  lock_armed       <= 1'b0;
               end else if (rx_sr[BYTE_W-1:0] == CMD_ED) begin
                  lock_armed <= 1'b1;
               end else if (rx_sr[BYTE_W-1:0] == CMD_FF) begin
                  resp1    <= RSP_AA;
                  resp_cnt <= 2'd2;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_device_emulator.sv
// Directed bench for ps2_device_emulator: a wired-AND bus model with a scripted host.
module tb_ps2_device_emulator;

   localparam int unsigned CLK_HALF    = 4;
   localparam int unsigned FIFO_DEPTH  = 16;
   localparam int unsigned GAP_CYC     = 6;
   localparam int unsigned INHIBIT_CYC = 10;

   logic       CLOCK_50   = 1'b0;
   logic       Resetn     = 1'b0;
   logic       key_action = 1'b0;
   logic [7:0] scan_code  = '0;
   logic       host_clk   = 1'b1;
   logic       host_dat   = 1'b1;
   logic       ps2_clk_o;
   logic       ps2_dat_o;
   logic       ps2_clk_i;
   logic       ps2_dat_i;
   logic [2:0] ps2_lock_control;
   logic       fifo_full;
   logic       overflow;
   logic       rx_error;

   int checks      = 0;
   int failures    = 0;
   int rx_err_seen = 0;

   assign ps2_clk_i = ps2_clk_o & host_clk;
   assign ps2_dat_i = ps2_dat_o & host_dat;

   ps2_device_emulator #(
      .CLK_HALF    (CLK_HALF),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .GAP_CYC     (GAP_CYC),
      .INHIBIT_CYC (INHIBIT_CYC)
   ) dut (
      .CLOCK_50         (CLOCK_50),
      .Resetn           (Resetn),
      .key_action       (key_action),
      .scan_code        (scan_code),
      .ps2_clk_o        (ps2_clk_o),
      .ps2_dat_o        (ps2_dat_o),
      .ps2_clk_i        (ps2_clk_i),
      .ps2_dat_i        (ps2_dat_i),
      .ps2_lock_control (ps2_lock_control),
      .fifo_full        (fifo_full),
      .overflow         (overflow),
      .rx_error         (rx_error)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (rx_error) rx_err_seen <= rx_err_seen + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected frame, bit i is the i-th bit on the wire.
   function automatic logic [10:0] exp_frame(input logic [7:0] d);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0), d, 1'b0};
   endfunction

   task automatic wait_fall(output bit ok);
      logic prev;
      ok   = 1'b0;
      prev = ps2_clk_i;
      for (int n = 0; n < 600; n++) begin
         @(negedge CLOCK_50);
         if (prev && !ps2_clk_i) begin
            ok = 1'b1;
            break;
         end
         prev = ps2_clk_i;
      end
   endtask

   task automatic recv_frame(output logic [10:0] f, output bit ok);
      bit got;
      f  = '1;
      ok = 1'b1;
      for (int i = 0; i < 11; i++) begin
         wait_fall(got);
         if (!got) begin
            ok = 1'b0;
            break;
         end
         f[i] = ps2_dat_i;
      end
   endtask

   task automatic rx_expect(input string tag, input logic [7:0] d);
      logic [10:0] f;
      bit          ok;
      recv_frame(f, ok);
      check({tag, "_done"}, 32'(ok), 32'd1);
      check(tag, 32'(f), 32'(exp_frame(d)));
   endtask

   task automatic count_falls(input int cycles, output int n);
      logic prev;
      n    = 0;
      prev = ps2_clk_i;
      repeat (cycles) begin
         @(negedge CLOCK_50);
         if (prev && !ps2_clk_i) n++;
         prev = ps2_clk_i;
      end
   endtask

   task automatic press(input logic [7:0] b);
      @(negedge CLOCK_50);
      key_action = 1'b1;
      scan_code  = b;
      @(negedge CLOCK_50);
      key_action = 1'b0;
   endtask

   // Host inhibits, requests to send, clocks out a byte and samples the device ACK.
   task automatic host_send(input logic [7:0] d, input bit bad_par, output bit ack);
      logic [10:0] fr;
      logic [9:0]  bits;
      bit          got;
      fr   = exp_frame(d);
      bits = {1'b1, fr[9] ^ bad_par, d};
      ack  = 1'b0;
      @(negedge CLOCK_50);
      host_clk = 1'b0;
      repeat (30) @(negedge CLOCK_50);
      host_dat = 1'b0;
      @(negedge CLOCK_50);
      host_clk = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_fall(got);
         if (!got) begin
            host_dat = 1'b1;
            return;
         end
         host_dat = bits[i];
      end
      wait_fall(got);
      if (got) ack = !ps2_dat_i;
      host_dat = 1'b1;
   endtask

   initial begin
      logic [10:0] part;
      bit          ok;
      bit          ack;
      int          n;
      int          err0;

      repeat (3) @(negedge CLOCK_50);
      check("rst_clk_o", 32'(ps2_clk_o), 32'd1);
      check("rst_dat_o", 32'(ps2_dat_o), 32'd1);
      check("rst_lock", 32'(ps2_lock_control), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_full", 32'(fifo_full), 32'd0);
      check("rst_rx_error", 32'(rx_error), 32'd0);
      Resetn = 1'b1;
      repeat (2) @(negedge CLOCK_50);

      // Single scan code 0x1C: 0,00111000,0,1 on the wire, then nothing more.
      press(8'h1C);
      recv_frame(part, ok);
      check("tx_1c_done", 32'(ok), 32'd1);
      check("tx_1c_bits", 32'(part), 32'h438);
      count_falls(80, n);
      check("tx_1c_single_pop", 32'(n), 32'd0);

      // Host aborts 0x5A at frame bit 5, then the byte is resent whole.
      press(8'h5A);
      part = '1;
      for (int i = 0; i < 5; i++) begin
         wait_fall(ok);
         part[i] = ps2_dat_i;
      end
      for (int i = 0; i < 50 && !ps2_clk_i; i++) @(negedge CLOCK_50);
      host_clk = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check("abort_release_clk", 32'(ps2_clk_o), 32'd1);
      check("abort_partial", 32'(part[4:0]), 32'h14);
      repeat (20) @(negedge CLOCK_50);
      host_clk = 1'b1;
      rx_expect("abort_resend_5a", 8'h5A);
      count_falls(80, n);
      check("abort_single_pop", 32'(n), 32'd0);

      // 17 strobes into a 16-deep queue while the bus is inhibited.
      host_clk = 1'b0;
      repeat (15) @(negedge CLOCK_50);
      for (int i = 0; i < 17; i++) press(8'(8'h10 + i));
      check("ovf_full", 32'(fifo_full), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
      repeat (5) @(negedge CLOCK_50);
      host_clk = 1'b1;
      for (int i = 0; i < 16; i++) rx_expect($sformatf("ovf_byte%0d", i), 8'(8'h10 + i));
      count_falls(100, n);
      check("ovf_dropped_17th", 32'(n), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_drained", 32'(fifo_full), 32'd0);

      // ED then 0x05 loads the lock LEDs.
      host_send(8'hED, 1'b0, ack);
      check("ed_ack", 32'(ack), 32'd1);
      rx_expect("ed_resp_fa", 8'hFA);
      host_send(8'h05, 1'b0, ack);
      check("lock_ack", 32'(ack), 32'd1);
      rx_expect("lock_resp_fa", 8'hFA);
      check("lock_value", 32'(ps2_lock_control), 32'h5);

      // ED with bad parity: error pulse, FE, lock untouched and capture not armed.
      err0 = rx_err_seen;
      host_send(8'hED, 1'b1, ack);
      rx_expect("badpar_resp_fe", 8'hFE);
      check("badpar_err_pulse", 32'(rx_err_seen - err0), 32'd1);
      check("badpar_lock", 32'(ps2_lock_control), 32'h5);
      host_send(8'h02, 1'b0, ack);
      rx_expect("plain_resp_fa", 8'hFA);
      check("not_armed_lock", 32'(ps2_lock_control), 32'h5);

      // FF answers FA then AA.
      host_send(8'hFF, 1'b0, ack);
      rx_expect("ff_resp_fa", 8'hFA);
      rx_expect("ff_resp_aa", 8'hAA);

      // Reset during the start bit releases both lines and empties the queue.
      press(8'hC3);
      press(8'h3C);
      wait_fall(ok);
      check("midtx_started", 32'(ok), 32'd1);
      check("midtx_start_bit", 32'(ps2_dat_o), 32'd0);
      Resetn = 1'b0;
      @(posedge CLOCK_50);
      #1;
      check("midtx_rst_clk", 32'(ps2_clk_o), 32'd1);
      check("midtx_rst_dat", 32'(ps2_dat_o), 32'd1);
      @(negedge CLOCK_50);
      Resetn = 1'b1;
      count_falls(200, n);
      check("midtx_queue_empty", 32'(n), 32'd0);
      check("midtx_overflow_clr", 32'(overflow), 32'd0);
      check("midtx_lock_clr", 32'(ps2_lock_control), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
